// File: rtl/seq_det_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_det_pkg : shared types and constants for the run controller  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package seq_det_pkg;

    localparam int DET_Z_W   = 2;
    localparam int NBITS_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    function automatic logic is_hit(input logic [DET_Z_W-1:0] z);
        return z != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_det : Moore detector, z=01 after 4 zeros, z=10 after 4 ones  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_det (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_w,
    output logic [1:0] o_z
);

    logic       r_last;
    logic [2:0] r_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
            r_run  <= 3'd0;
        end else if (r_run == 3'd0 || i_w != r_last) begin
            r_last <= i_w;
            r_run  <= 3'd1;
        end else if (r_run != 3'd4) begin
            r_run  <= r_run + 3'd1;
        end
    end

    assign o_z = (r_run == 3'd4) ? (r_last ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl_hit_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hit_tracker : per-word hit count and first-hit index             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hit_tracker
    import seq_det_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr,
    input  logic                         i_sample,
    input  logic [$clog2(NBITS)-1:0]     i_idx,
    input  logic [DET_Z_W-1:0]           i_det_z,
    output logic [$clog2(NBITS+1)-1:0]   o_hits,
    output logic [$clog2(NBITS+1)-1:0]   o_hits_nxt,
    output logic                         o_first_vld,
    output logic [$clog2(NBITS)-1:0]     o_first
);

    localparam int HW = $clog2(NBITS+1);
    localparam int IW = $clog2(NBITS);

    logic          w_hit;
    logic [HW-1:0] r_hits;
    logic          r_first_vld;
    logic [IW-1:0] r_first;

    assign w_hit      = i_sample & is_hit(i_det_z);
    // Exposed so the running total can include the final sample in the same edge.
    assign o_hits_nxt = r_hits + HW'(w_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hits      <= '0;
            r_first_vld <= 1'b0;
            r_first     <= '0;
        end else if (i_clr) begin
            r_hits      <= '0;
            r_first_vld <= 1'b0;
            r_first     <= '0;
        end else begin
            r_hits <= o_hits_nxt;
            if (w_hit && !r_first_vld) begin
                r_first_vld <= 1'b1;
                r_first     <= i_idx;
            end
        end
    end

    assign o_hits      = r_hits;
    assign o_first_vld = r_first_vld;
    assign o_first     = r_first;

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_det_ctrl : word-level serializer/controller for seq_det      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NBITS-1:0]             in_data,
    output logic                         det_w,
    output logic                         det_rst,
    input  logic [DET_Z_W-1:0]           det_z,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(NBITS+1)-1:0]   res_hits,
    output logic                         res_first_vld,
    output logic [$clog2(NBITS)-1:0]     res_first,
    input  logic                         stat_clr,
    output logic [CNT_W-1:0]             total_hits
);

    localparam int HW = $clog2(NBITS+1);
    localparam int IW = $clog2(NBITS);
    localparam int SW = ((CNT_W > HW) ? CNT_W : HW) + 1;
    localparam logic [SW-1:0] c_cnt_max = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    state_t            r_state, w_state_nxt;
    logic [NBITS-1:0]  r_shift;
    logic [IW-1:0]     r_idx;
    logic              r_det_rst;
    logic [CNT_W-1:0]  r_total;
    logic              w_accept;
    logic              w_sample;
    logic [IW-1:0]     w_sidx;
    logic [HW-1:0]     w_hits_nxt;
    logic [SW-1:0]     w_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_INIT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_sidx      = '0;
        case (r_state)
            ST_INIT:   w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // det_z lags one cycle behind det_w: this cycle reports the previous bit
                w_sample = (r_idx != '0);
                w_sidx   = r_idx - IW'(1);
                if (r_idx == IW'(NBITS-1)) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_sample    = 1'b1;
                w_sidx      = IW'(NBITS-1);
                w_state_nxt = ST_REPORT;
            end
            ST_REPORT: if (res_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_idx     <= '0;
            r_det_rst <= 1'b1;
        end else begin
            r_det_rst <= !(w_state_nxt == ST_SHIFT || w_state_nxt == ST_WAIT);
            if (w_accept) begin
                r_shift <= in_data;
                r_idx   <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_shift <= {r_shift[NBITS-2:0], 1'b0};
                r_idx   <= r_idx + IW'(1);
            end
        end
    end

    hit_tracker #(
        .NBITS (NBITS)
    ) u_hit_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_accept),
        .i_sample    (w_sample),
        .i_idx       (w_sidx),
        .i_det_z     (det_z),
        .o_hits      (res_hits),
        .o_hits_nxt  (w_hits_nxt),
        .o_first_vld (res_first_vld),
        .o_first     (res_first)
    );

    assign w_sum = SW'(r_total) + SW'(w_hits_nxt);

    // WAIT always leads to REPORT, so updating on the WAIT edge is the REPORT-entry update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_total <= '0;
        else if (stat_clr)
            r_total <= '0;
        else if (r_state == ST_WAIT)
            r_total <= (w_sum > c_cnt_max) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign res_valid  = (r_state == ST_REPORT);
    assign det_w      = (r_state == ST_SHIFT) & r_shift[NBITS-1];
    assign det_rst    = r_det_rst;
    assign total_hits = r_total;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// Directed bench: two controllers (16-bit and 4-bit totals) share stimulus,
// each driving its own detector instance.
module tb_seq_det_ctrl;

    localparam int NB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       res_ready = 1'b1;
    logic       stat_clr = 1'b0;

    logic       in_ready, det_w, det_rst, res_valid, res_first_vld;
    logic [1:0] det_z;
    logic [3:0] res_hits;
    logic [2:0] res_first;
    logic [15:0] total_hits;

    logic       in_ready4, det_w4, det_rst4, res_valid4, res_first_vld4;
    logic [1:0] det_z4;
    logic [3:0] res_hits4;
    logic [2:0] res_first4;
    logic [3:0] total_hits4;

    always #5 clk = ~clk;

    seq_det_ctrl #(.NBITS(NB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .det_w(det_w), .det_rst(det_rst), .det_z(det_z),
        .res_valid(res_valid), .res_ready(res_ready), .res_hits(res_hits),
        .res_first_vld(res_first_vld), .res_first(res_first),
        .stat_clr(stat_clr), .total_hits(total_hits)
    );
    seq_det u_det (.clk(clk), .rst(det_rst), .i_w(det_w), .o_z(det_z));

    seq_det_ctrl #(.NBITS(NB), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .det_w(det_w4), .det_rst(det_rst4), .det_z(det_z4),
        .res_valid(res_valid4), .res_ready(res_ready), .res_hits(res_hits4),
        .res_first_vld(res_first_vld4), .res_first(res_first4),
        .stat_clr(stat_clr), .total_hits(total_hits4)
    );
    seq_det u_det4 (.clk(clk), .rst(det_rst4), .i_w(det_w4), .o_z(det_z4));

    typedef struct {
        logic [7:0] word;
        int         hits;
        logic       fv;
        int         first;
    } vec_t;

    vec_t vecs[8];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp16  = 0;
    int   exp4   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add_total(input int h);
        exp16 = exp16 + h;
        exp4  = (exp4 + h > 15) ? 15 : exp4 + h;
    endtask

    // Leaves the caller at the falling edge of the first REPORT cycle.
    task automatic send_word(input logic [7:0] w, input bit clr_wait);
        int n;
        logic [7:0] cap;
        n = 0;
        cap = 8'h00;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (n < 40) begin
            if (res_valid) break;
            if (n <= NB) cap[NB-n] = det_w;
            if (n == 1) begin
                chk("det_rst_shift", det_rst, 0);
                chk("in_ready_shift", in_ready, 0);
            end
            stat_clr = clr_wait && (n == NB + 1);
            @(negedge clk);
            n++;
        end
        stat_clr = 1'b0;
        chk("latency", n, NB + 2);
        chk("det_w_serial", cap, w);
    endtask

    task automatic check_result(input int hits, input logic fv, input int first);
        chk("res_hits", res_hits, hits);
        chk("res_first_vld", res_first_vld, fv);
        chk("res_first", res_first, first);
        chk("det_rst_report", det_rst, 1);
        chk("total16", total_hits, exp16);
        chk("total4", total_hits4, exp4);
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_det_rst", det_rst, 1);
        chk("rst_det_w", det_w, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_hits", res_hits, 0);
        chk("rst_first_vld", res_first_vld, 0);
        chk("rst_first", res_first, 0);
        chk("rst_total", total_hits, 0);
    endtask

    initial begin
        int acc;
        int seen;
        vecs[0] = '{8'h00, 5, 1'b1, 3};
        vecs[1] = '{8'hFF, 5, 1'b1, 3};
        vecs[2] = '{8'hAA, 0, 1'b0, 0};
        vecs[3] = '{8'h0F, 2, 1'b1, 3};
        vecs[4] = '{8'hF0, 2, 1'b1, 3};
        vecs[5] = '{8'h87, 1, 1'b1, 4};
        vecs[6] = '{8'h1E, 1, 1'b1, 6};
        vecs[7] = '{8'hFE, 4, 1'b1, 3};

        // Reset values, then INIT lasts one cycle after release.
        repeat (3) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("init_in_ready", in_ready, 0);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].word, 1'b0);
            add_total(vecs[i].hits);
            check_result(vecs[i].hits, vecs[i].fv, vecs[i].first);
            @(negedge clk);
        end

        // Back-pressure with a word waiting.
        res_ready = 1'b0;
        send_word(8'hFF, 1'b0);
        add_total(5);
        check_result(5, 1'b1, 3);
        in_data  = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_det_rst", det_rst, 1);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_hits", res_hits, 5);
            chk("bp_first", res_first, 3);
        end
        res_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc, 1);
        seen = 0;
        while (!res_valid && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        add_total(5);
        chk("bp_word_valid", res_valid, 1);
        check_result(5, 1'b1, 3);
        @(negedge clk);

        // stat_clr coinciding with REPORT entry wins over the update.
        send_word(8'h00, 1'b1);
        exp16 = 0;
        exp4  = 0;
        check_result(5, 1'b1, 3);
        @(negedge clk);

        // Saturation of the 4-bit total.
        for (int i = 0; i < 4; i++) begin
            send_word(8'h00, 1'b0);
            add_total(5);
            check_result(5, 1'b1, 3);
            @(negedge clk);
        end

        // Reset during SHIFT bit 4 aborts the word.
        in_data  = 8'h00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        exp16 = 0;
        exp4  = 0;
        send_word(8'h00, 1'b0);
        add_total(5);
        check_result(5, 1'b1, 3);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks, expected completion", n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Word-level controller for the serial run detector (the 4-zeros / 4-ones Moore detector with `w` in and 2-bit `z` out). Accepts parallel words over a valid/ready handshake, holds the detector in reset between words, serializes each word MSB-first onto the detector's `w`, and samples `z` after every bit. Returns a per-word result over a second valid/ready handshake and keeps a saturating running hit total. Sits between the word-oriented host logic and one detector instance.

## Interface
- `NBITS`, 8, word width and bits shifted per word (≥2)
- `CNT_W`, 16, width of `total_hits`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  word offered
- `in_ready`  out  1  controller can accept a word
- `in_data`  in  NBITS  word; bit NBITS-1 is shifted first
- `det_w`  out  1  serial bit to detector `w`
- `det_rst`  out  1  registered, active-high reset to detector
- `det_z`  in  2  detector output; nonzero = hit
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed
- `res_hits`  out  clog2(NBITS+1)  hits counted in the word
- `res_first_vld`  out  1  at least one hit in the word
- `res_first`  out  clog2(NBITS)  bit index (0 = first shifted) of first hit
- `stat_clr`  in  1  synchronous clear of `total_hits`
- `total_hits`  out  CNT_W  saturating sum of `res_hits`

## Operation
- States: INIT, IDLE, SHIFT, WAIT, REPORT.
- INIT: entered on reset; lasts one cycle after `rst` releases; `det_rst`=1, `in_ready`=0; → IDLE.
- IDLE: `in_ready`=1, `det_rst`=1. On `in_valid & in_ready`, latch `in_data`, clear bit index, hit count and first flag; → SHIFT.
- SHIFT: NBITS cycles; cycle i drives `det_w` = latched bit NBITS-1-i; `det_rst`=0. After cycle NBITS-1 → WAIT.
- WAIT: one cycle, `det_rst`=0, `det_w`=0 (the detector's consumption of this bit is irrelevant).
- Sampling: `det_z` in the cycle after the bit is driven reflects that bit. Sample bit i in SHIFT cycle i+1 (i < NBITS-1) and in WAIT for bit NBITS-1. Every nonzero sample increments the hit count; the first nonzero sample sets `res_first_vld` and `res_first`=i.
- REPORT: `res_valid`=1, result outputs stable; `det_rst`=1. On `res_valid & res_ready` → IDLE. On entry to REPORT, `total_hits` += `res_hits`, saturating at all-ones.
- `stat_clr` zeroes `total_hits` on any cycle. If it coincides with the REPORT-entry update, clear wins and the update is discarded.
- `in_ready` is 0 outside IDLE. `in_data` and `in_valid` are ignored outside IDLE.
- Back-pressure: `res_ready` held low keeps the controller in REPORT indefinitely, with the detector held in reset.
- Each word starts with the detector in its initial state. There is no run history across words.

## Timing
- Reset values: `in_ready`=0, `det_rst`=1, `det_w`=0, `res_valid`=0, `res_hits`=0, `res_first_vld`=0, `res_first`=0, `total_hits`=0.
- `rst` asserted mid-word aborts the word: state returns to INIT and no result is produced.
- `det_rst` is a flop output. It falls at the edge entering SHIFT, so the detector is still in reset at that edge and starts in its initial state.
- Latency: handshake accepted at edge t. SHIFT occupies cycles t+1..t+NBITS, WAIT occupies t+NBITS+1, and `res_valid` rises in cycle t+NBITS+2.
- Throughput: one word per NBITS+3 cycles when `res_ready`=1 (REPORT 1 cycle, IDLE 1 cycle).
- `total_hits` is visible updated in the first REPORT cycle.

## Structure
- Package `seq_det_pkg`:
  - state enum
  - `DET_Z_W`=2
  - default `NBITS`/`CNT_W`
  - hit predicate (`det_z != 0`)
- Sub-module `hit_tracker`: sample strobe, bit index and `det_z` in; hit count, first-hit flag and index out; synchronous clear on word accept.
- FSM, shift register and handshakes live in `seq_det_ctrl`.
- Bench instantiates the real detector on `det_w`/`det_rst`/`det_z`.

## Test plan
- Word 0x00, `res_ready`=1 → `res_hits`=5, `res_first_vld`=1, `res_first`=3; `res_valid` in cycle t+10.
- Word 0xFF → hits 5, first 3. Then 0xAA → hits 0, `res_first_vld`=0. `total_hits`=5 after the first word and unchanged by the second.
- Words 0x0F and 0xF0 → each gives hits 2, first 3; `total_hits` accumulates to 4.
- `res_ready` low for 20 cycles with `in_valid` high → `in_ready`=0 and `det_rst`=1 throughout. `res_*` stay stable; exactly one word is accepted after release.
- Set `CNT_W`=4 and send four 0x00 words → `total_hits` saturates at 15. `stat_clr` in a REPORT-entry cycle → `total_hits`=0.
- `rst` low during SHIFT bit 4 → no `res_valid`, all outputs at reset values. The next word 0x00 yields hits 5.
